// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the frame-buffer write port, with a full-buffer clear sweep.
// Writes leave through registered mem_we/mem_addr/mem_wdata one cycle after the grant.
module fb_write_arbiter #(
    parameter int                    NREQ        = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 6,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       clear_start,
    output logic                       clear_busy,
    output logic                       clear_done,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // The sweep counter carries one extra bit so "all words issued" is distinct from address 0.
    localparam logic [ADDR_WIDTH:0] CNT_END = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [ADDR_WIDTH:0]     clr_cnt_reg, clr_cnt_next;
    logic                    mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                    clear_done_reg, clear_done_next;

    logic [ADDR_WIDTH-1:0]   addr_slice [NREQ];
    logic [DATA_WIDTH-1:0]   data_slice [NREQ];
    logic                    grant_any;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        cand;
    logic                    arb_enable;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_slice[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_reg) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // A clear request in IDLE wins over any same-cycle write request.
    assign arb_enable = (state_reg == IDLE) && !clear_start;

    always_comb begin
        req_ready = '0;
        if (arb_enable && grant_any)
            req_ready = NREQ'(1) << grant_idx;
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        clr_cnt_next    = clr_cnt_reg;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        clear_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clear_start) begin
                    state_next     = CLEAR;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = '0;
                    mem_wdata_next = CLEAR_VALUE;
                    clr_cnt_next   = (ADDR_WIDTH+1)'(1);
                end else if (grant_any) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = addr_slice[grant_idx];
                    mem_wdata_next = data_slice[grant_idx];
                    rr_ptr_next    = (grant_idx == PTR_W'(NREQ-1)) ? '0
                                                                   : PTR_W'(grant_idx + 1'b1);
                end
            end
            CLEAR: begin
                if (clr_cnt_reg == CNT_END) begin
                    state_next      = IDLE;
                    clear_done_next = 1'b1;
                end else begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = clr_cnt_reg[ADDR_WIDTH-1:0];
                    mem_wdata_next = CLEAR_VALUE;
                    clr_cnt_next   = clr_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            clr_cnt_reg    <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            clear_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            clr_cnt_reg    <= clr_cnt_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            clear_done_reg <= clear_done_next;
        end
    end

    assign clear_busy = (state_reg == CLEAR);
    assign clear_done = clear_done_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: arbitration order, write latency, clear sweep and reset.
module tb_fb_write_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;

    int passed = 0;
    int total  = 0;

    fb_write_arbiter #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(8'h00)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    int gl [8] = '{2, 3, 0, 1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        clear_start = 1'b0;
        #12;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        tick();
        rst = 1'b0;

        // 1 single write from requester 1
        set_req(1, 6'h15, 8'hA5);
        req_valid = 4'b0010;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h15);
        chk("t1_wdata", 32'(mem_wdata), 32'hA5);
        $display("t1 single write addr=%h data=%h", mem_addr, mem_wdata);

        // 2 fairness: rr_ptr is 2 after test 1
        for (int i = 0; i < NREQ; i++) set_req(i, 6'(6'h20 + i), 8'(8'hC0 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_ready", 32'(req_ready), 32'(1) << gl[k]);
            tick();
            chk("t2_we", 32'(mem_we), 32'd1);
            chk("t2_addr", 32'(mem_addr), 32'h20 + 32'(gl[k]));
            chk("t2_wdata", 32'(mem_wdata), 32'hC0 + 32'(gl[k]));
            $display("t2 grant %0d addr=%h", gl[k], mem_addr);
        end

        // 3 skip/wrap: move rr_ptr to 3, then valid=0101 grants 0 then 2
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0101;
        #1;
        chk("t3_ready0", 32'(req_ready), 32'h1);
        tick();
        chk("t3_addr0", 32'(mem_addr), 32'h20);
        req_valid = 4'b0100;
        #1;
        chk("t3_ready2", 32'(req_ready), 32'h4);
        tick();
        chk("t3_addr2", 32'(mem_addr), 32'h22);
        req_valid = 4'b0000;
        #1;
        chk("t3_ready_none", 32'(req_ready), 32'h0);
        tick();
        chk("t3_we_idle", 32'(mem_we), 32'd0);
        chk("t3_addr_hold", 32'(mem_addr), 32'h22);
        chk("t3_wdata_hold", 32'(mem_wdata), 32'hC2);
        // rr_ptr held at 3: with 0 and 3 valid, 3 must win
        req_valid = 4'b1001;
        #1;
        chk("t3_rr_hold", 32'(req_ready), 32'h8);
        tick();
        chk("t3_addr3", 32'(mem_addr), 32'h23);
        $display("t3 skip/wrap done, last addr=%h", mem_addr);

        // 4 clear sweep with all requesters pending (rr_ptr now 0)
        req_valid = 4'b1111;
        clear_start = 1'b1;
        #1;
        chk("t4_ready_start", 32'(req_ready), 32'h0);
        for (int k = 0; k < 64; k++) begin
            tick();
            clear_start = 1'b0;
            chk("t4_ready", 32'(req_ready), 32'h0);
            chk("t4_we", 32'(mem_we), 32'd1);
            chk("t4_addr", 32'(mem_addr), 32'(k));
            chk("t4_wdata", 32'(mem_wdata), 32'h00);
            chk("t4_busy", 32'(clear_busy), 32'd1);
            chk("t4_done", 32'(clear_done), 32'd0);
        end
        tick();
        chk("t4_done_pulse", 32'(clear_done), 32'd1);
        chk("t4_busy_end", 32'(clear_busy), 32'd0);
        chk("t4_we_end", 32'(mem_we), 32'd0);
        chk("t4_resume", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("t4_done_clr", 32'(clear_done), 32'd0);
        chk("t4_resume_we", 32'(mem_we), 32'd1);
        chk("t4_resume_addr", 32'(mem_addr), 32'h20);
        $display("t4 clear sweep of 64 words done");

        // 5 tie with clear_start, then a second clear_start mid-sweep (rr_ptr now 1)
        req_valid = 4'b0001;
        clear_start = 1'b1;
        #1;
        chk("t5_tie_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 64; k++) begin
            tick();
            clear_start = (k == 20);
            chk("t5_we", 32'(mem_we), 32'd1);
            chk("t5_addr", 32'(mem_addr), 32'(k));
            chk("t5_wdata", 32'(mem_wdata), 32'h00);
            chk("t5_busy", 32'(clear_busy), 32'd1);
        end
        clear_start = 1'b0;
        tick();
        chk("t5_done_pulse", 32'(clear_done), 32'd1);
        chk("t5_we_end", 32'(mem_we), 32'd0);
        chk("t5_resume", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("t5_resume_addr", 32'(mem_addr), 32'h20);
        $display("t5 tie/ignore done");

        // 6 reset in the middle of a sweep
        clear_start = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            tick();
            clear_start = 1'b0;
            chk("t6_addr", 32'(mem_addr), 32'(k));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_we", 32'(mem_we), 32'd0);
        chk("t6_rst_addr", 32'(mem_addr), 32'd0);
        chk("t6_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("t6_rst_busy", 32'(clear_busy), 32'd0);
        chk("t6_rst_done", 32'(clear_done), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_done", 32'(clear_done), 32'd0);
            chk("t6_idle_we", 32'(mem_we), 32'd0);
        end
        req_valid = 4'b1000;
        #1;
        chk("t6_ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        chk("t6_we", 32'(mem_we), 32'd1);
        chk("t6_addr3", 32'(mem_addr), 32'h23);
        chk("t6_wdata3", 32'(mem_wdata), 32'hC3);
        $display("t6 reset mid-clear done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
